// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Request, response and shared-ALU bundle for alu_share_arbiter.
//               The master side is issue logic plus the ALU instance; the
//               slave side is the arbiter itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 7
);
  // Request port 0 (integer issue path)
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_rs1;
  logic [DATA_WIDTH-1:0] req0_rs2;
  logic [CTRL_WIDTH-1:0] req0_aluControl;
  // Request port 1 (branch/compare unit)
  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_rs1;
  logic [DATA_WIDTH-1:0] req1_rs2;
  logic [CTRL_WIDTH-1:0] req1_aluControl;
  // Response ports
  logic                  resp0_valid;
  logic                  resp0_ready;
  logic [DATA_WIDTH-1:0] resp0_rd;
  logic                  resp0_zero;
  logic                  resp0_err;
  logic                  resp1_valid;
  logic                  resp1_ready;
  logic [DATA_WIDTH-1:0] resp1_rd;
  logic                  resp1_zero;
  logic                  resp1_err;
  // Shared combinational ALU
  logic [DATA_WIDTH-1:0] alu_rs1;
  logic [DATA_WIDTH-1:0] alu_rs2;
  logic [CTRL_WIDTH-1:0] alu_aluControl;
  logic [DATA_WIDTH-1:0] alu_rd;
  // Status
  logic                  busy;

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_aluControl,
    input  req1_valid, req1_rs1, req1_rs2, req1_aluControl,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rd, resp0_zero, resp0_err,
    output resp1_valid, resp1_rd, resp1_zero, resp1_err,
    input  resp0_ready, resp1_ready,
    output alu_rs1, alu_rs2, alu_aluControl,
    input  alu_rd,
    output busy
  );

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_aluControl,
    output req1_valid, req1_rs1, req1_rs2, req1_aluControl,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rd, resp0_zero, resp0_err,
    input  resp1_valid, resp1_rd, resp1_zero, resp1_err,
    output resp0_ready, resp1_ready,
    input  alu_rs1, alu_rs2, alu_aluControl,
    output alu_rd,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one combinational ALU between two
//               valid/ready requesters. One operation in flight at a time:
//               accept -> drive ALU -> register result -> hold response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   bus
);

  localparam logic [CTRL_WIDTH-1:0] CODE_MAX = CTRL_WIDTH'(10);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_grant;
  logic                  owner;
  logic [DATA_WIDTH-1:0] op_rs1;
  logic [DATA_WIDTH-1:0] op_rs2;
  logic [CTRL_WIDTH-1:0] op_ctrl;
  logic [DATA_WIDTH-1:0] res_rd;
  logic                  res_zero;
  logic                  res_err;
  logic                  grant0;
  logic                  grant1;
  logic                  take;
  logic                  resp_fire;

  // Arbitration: a lone requester wins; on a tie the port that did not win last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state == IDLE)) begin
      grant0 = bus.req0_valid && (!bus.req1_valid ||  last_grant);
      grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end
  end

  assign take      = grant0 || grant1;
  assign resp_fire = (state == RESP) && (owner ? bus.resp1_ready : bus.resp0_ready);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept -> one execute cycle -> hold response until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on handshake, result capture at the end of the execute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_rs1     <= '0;
      op_rs2     <= '0;
      op_ctrl    <= '0;
      res_rd     <= '0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      if (take) begin
        owner      <= grant1;
        last_grant <= grant1;
        op_rs1     <= grant1 ? bus.req1_rs1        : bus.req0_rs1;
        op_rs2     <= grant1 ? bus.req1_rs2        : bus.req0_rs2;
        op_ctrl    <= grant1 ? bus.req1_aluControl : bus.req0_aluControl;
      end
      if (state == EXEC) begin
        res_rd   <= bus.alu_rd;
        res_zero <= (bus.alu_rd == '0);
        res_err  <= (op_ctrl == '0) || (op_ctrl > CODE_MAX);
      end
    end
  end

  assign bus.req0_ready     = grant0;
  assign bus.req1_ready     = grant1;

  // The ALU always sees the latched operands, including illegal codes.
  assign bus.alu_rs1        = op_rs1;
  assign bus.alu_rs2        = op_rs2;
  assign bus.alu_aluControl = op_ctrl;

  // Only the owning port ever shows a response.
  assign bus.resp0_valid    = (state == RESP) && !owner;
  assign bus.resp1_valid    = (state == RESP) &&  owner;
  assign bus.resp0_rd       = owner ? '0   : res_rd;
  assign bus.resp0_zero     = owner ? 1'b0 : res_zero;
  assign bus.resp0_err      = owner ? 1'b0 : res_err;
  assign bus.resp1_rd       = owner ? res_rd   : '0;
  assign bus.resp1_zero     = owner ? res_zero : 1'b0;
  assign bus.resp1_err      = owner ? res_err  : 1'b0;

  assign bus.busy           = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter. A transaction-level
//               model predicts grants and responses; directed cases pin
//               literal results, then a randomized sweep runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  alu_share_arbiter_if bus ();

  alu_share_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ALU semantics; illegal codes yield zero.
  function automatic logic [31:0] alu_ref(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    case (c)
      7'd1:  r = a + b;
      7'd2:  r = a - b;
      7'd3:  r = a << b[4:0];
      7'd4:  r = {31'd0, $signed(a) < $signed(b)};
      7'd5:  r = {31'd0, a < b};
      7'd6:  r = a ^ b;
      7'd7:  r = a >> b[4:0];
      7'd8:  r = $unsigned($signed(a) >>> b[4:0]);
      7'd9:  r = a | b;
      7'd10: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // The shared ALU instance seen by the arbiter.
  always_comb bus.alu_rd = alu_ref(bus.alu_aluControl, bus.alu_rs1, bus.alu_rs2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_stage counts progress of the single in-flight op: 0 none, 1 accepted, 2 result shown.
  int          m_stage = 0;
  logic        m_owner = 1'b0;
  logic        m_last  = 1'b1;
  logic [31:0] m_rs1   = '0;
  logic [31:0] m_rs2   = '0;
  logic [6:0]  m_ctrl  = '0;
  logic [31:0] m_rd    = '0;
  logic        m_zero  = 1'b0;
  logic        m_err   = 1'b0;

  function automatic logic m_grant(input logic p);
    logic v0, v1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    if (!rst_n || m_stage != 0) return 1'b0;
    if (!p) return v0 && (!v1 || m_last);
    return v1 && (!v0 || !m_last);
  endfunction

  // Advance the model; the whole answer is computed from the requester's operands at acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stage <= 0; m_owner <= 1'b0; m_last <= 1'b1;
      m_rs1 <= '0; m_rs2 <= '0; m_ctrl <= '0;
      m_rd <= '0; m_zero <= 1'b0; m_err <= 1'b0;
    end else if (m_stage == 0) begin
      if (m_grant(1'b0)) begin
        m_stage <= 1; m_owner <= 1'b0; m_last <= 1'b0;
        m_rs1 <= bus.req0_rs1; m_rs2 <= bus.req0_rs2; m_ctrl <= bus.req0_aluControl;
        m_rd   <= alu_ref(bus.req0_aluControl, bus.req0_rs1, bus.req0_rs2);
        m_zero <= alu_ref(bus.req0_aluControl, bus.req0_rs1, bus.req0_rs2) == 32'd0;
        m_err  <= (bus.req0_aluControl == 7'd0) || (bus.req0_aluControl > 7'd10);
      end else if (m_grant(1'b1)) begin
        m_stage <= 1; m_owner <= 1'b1; m_last <= 1'b1;
        m_rs1 <= bus.req1_rs1; m_rs2 <= bus.req1_rs2; m_ctrl <= bus.req1_aluControl;
        m_rd   <= alu_ref(bus.req1_aluControl, bus.req1_rs1, bus.req1_rs2);
        m_zero <= alu_ref(bus.req1_aluControl, bus.req1_rs1, bus.req1_rs2) == 32'd0;
        m_err  <= (bus.req1_aluControl == 7'd0) || (bus.req1_aluControl > 7'd10);
      end
    end else if (m_stage == 1) begin
      m_stage <= 2;
    end else if (m_owner ? bus.resp1_ready : bus.resp0_ready) begin
      m_stage <= 0;
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    chk("req0_ready",  {31'd0, bus.req0_ready},  {31'd0, m_grant(1'b0)});
    chk("req1_ready",  {31'd0, bus.req1_ready},  {31'd0, m_grant(1'b1)});
    chk("resp0_valid", {31'd0, bus.resp0_valid}, {31'd0, (m_stage == 2) && !m_owner});
    chk("resp1_valid", {31'd0, bus.resp1_valid}, {31'd0, (m_stage == 2) &&  m_owner});
    chk("busy",        {31'd0, bus.busy},        {31'd0, m_stage != 0});
    chk("alu_rs1",     bus.alu_rs1,              m_rs1);
    chk("alu_rs2",     bus.alu_rs2,              m_rs2);
    chk("alu_ctrl",    {25'd0, bus.alu_aluControl}, {25'd0, m_ctrl});
    if (m_stage == 2 && !m_owner) begin
      chk("resp0_rd",   bus.resp0_rd,              m_rd);
      chk("resp0_zero", {31'd0, bus.resp0_zero},   {31'd0, m_zero});
      chk("resp0_err",  {31'd0, bus.resp0_err},    {31'd0, m_err});
    end
    if (m_stage == 2 && m_owner) begin
      chk("resp1_rd",   bus.resp1_rd,              m_rd);
      chk("resp1_zero", {31'd0, bus.resp1_zero},   {31'd0, m_zero});
      chk("resp1_err",  {31'd0, bus.resp1_err},    {31'd0, m_err});
    end
    if (!rst_n) begin
      chk("rst_rd0",  bus.resp0_rd, 32'd0);
      chk("rst_rd1",  bus.resp1_rd, 32'd0);
      chk("rst_flags", {28'd0, bus.resp0_zero, bus.resp0_err, bus.resp1_zero, bus.resp1_err}, 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic v, input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
    if (!p) begin
      bus.req0_valid = v; bus.req0_aluControl = c; bus.req0_rs1 = a; bus.req0_rs2 = b;
    end else begin
      bus.req1_valid = v; bus.req1_aluControl = c; bus.req1_rs1 = a; bus.req1_rs2 = b;
    end
  endtask

  function automatic logic [31:0] p_ready(input logic p);
    return {31'd0, p ? bus.req1_ready : bus.req0_ready};
  endfunction
  function automatic logic [31:0] p_rvalid(input logic p);
    return {31'd0, p ? bus.resp1_valid : bus.resp0_valid};
  endfunction

  // Issue one op on port p (response ready assumed high) and check literal results.
  task automatic issue(input logic p, input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] erd, input logic ez, input logic ee, input string tag);
    int n;
    n = 0;
    set_req(p, 1'b1, c, a, b);
    #2;
    while (p_ready(p) != 32'd1 && n < 10) begin
      step(); #2; n++;
    end
    chk({tag, "_ready"}, p_ready(p), 32'd1);
    step();
    set_req(p, 1'b0, c, a, b);
    #2;
    chk({tag, "_exec_noresp"}, p_rvalid(p), 32'd0);
    step(); #2;
    chk({tag, "_valid"}, p_rvalid(p), 32'd1);
    chk({tag, "_other"}, p_rvalid(!p), 32'd0);
    chk({tag, "_rd"},   p ? bus.resp1_rd : bus.resp0_rd, erd);
    chk({tag, "_zero"}, {31'd0, p ? bus.resp1_zero : bus.resp0_zero}, {31'd0, ez});
    chk({tag, "_err"},  {31'd0, p ? bus.resp1_err  : bus.resp0_err},  {31'd0, ee});
    step();
    #2;
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    step();
  endtask

  // Both ports request together; port 0 is expected to win first, port 1 next.
  task automatic contend(input logic [6:0] c0, input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] e0,
                         input logic [6:0] c1, input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                         input string tag);
    set_req(1'b0, 1'b1, c0, a0, b0);
    set_req(1'b1, 1'b1, c1, a1, b1);
    #2;
    chk({tag, "_tie_r0"}, p_ready(1'b0), 32'd1);
    chk({tag, "_tie_r1"}, p_ready(1'b1), 32'd0);
    step();
    set_req(1'b0, 1'b0, c0, a0, b0);
    #2;
    chk({tag, "_r1_exec"}, p_ready(1'b1), 32'd0);
    step(); #2;
    chk({tag, "_resp0"},    p_rvalid(1'b0), 32'd1);
    chk({tag, "_rd0"},      bus.resp0_rd, e0);
    step(); #2;
    chk({tag, "_r1_idle"},  p_ready(1'b1), 32'd1);
    step();
    set_req(1'b1, 1'b0, c1, a1, b1);
    step(); #2;
    chk({tag, "_resp1"},    p_rvalid(1'b1), 32'd1);
    chk({tag, "_resp0_lo"}, p_rvalid(1'b0), 32'd0);
    chk({tag, "_rd1"},      bus.resp1_rd, e1);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_req(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 7'd0, 32'd0, 32'd0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("reset_busy",    {31'd0, bus.busy},        32'd0);
    chk("reset_resp0",   {31'd0, bus.resp0_valid}, 32'd0);
    chk("reset_alu_rs1", bus.alu_rs1,              32'd0);
    step();

    // Single ADD on port 0.
    issue(1'b0, 7'd1, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, "add0");

    // Contention from reset, then a second contended pair.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    contend(7'd2, 32'd3, 32'd3, 32'd0, 7'd8, 32'h8000_0000, 32'd4, 32'hF800_0000, "pair1");
    contend(7'd1, 32'd1, 32'd1, 32'd2, 7'd6, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, "pair2");

    // Back-pressure on port 1 with port 0 waiting.
    bus.resp1_ready = 1'b0;
    set_req(1'b1, 1'b1, 7'd5, 32'd1, 32'd2);
    #2;
    chk("bp_ready1", p_ready(1'b1), 32'd1);
    step();
    set_req(1'b1, 1'b0, 7'd5, 32'd1, 32'd2);
    set_req(1'b0, 1'b1, 7'd9, 32'hA0, 32'h0B);
    step();
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_valid",  p_rvalid(1'b1), 32'd1);
      chk("bp_rd",     bus.resp1_rd,   32'd1);
      chk("bp_ready0", p_ready(1'b0),  32'd0);
      step();
    end
    bus.resp1_ready = 1'b1;
    #2;
    chk("bp_release", p_rvalid(1'b1), 32'd1);
    step(); #2;
    chk("bp_idle",    {31'd0, bus.busy}, 32'd0);
    chk("bp_next_r0", p_ready(1'b0),     32'd1);
    step();
    set_req(1'b0, 1'b0, 7'd9, 32'hA0, 32'h0B);
    step(); #2;
    chk("bp_or_rd", bus.resp0_rd, 32'hAB);
    step(); step();

    // Illegal codes.
    issue(1'b0, 7'd0,   32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "ill0");
    issue(1'b0, 7'd11,  32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "ill11");
    issue(1'b1, 7'd127, 32'd9, 32'd1, 32'd0, 1'b1, 1'b1, "ill127");

    // Reset during execute.
    set_req(1'b0, 1'b1, 7'd1, 32'd5, 32'd5);
    #2;
    chk("mid_ready", p_ready(1'b0), 32'd1);
    step();
    set_req(1'b0, 1'b0, 7'd1, 32'd5, 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_busy",  {31'd0, bus.busy},        32'd0);
    chk("mid_alu",   bus.alu_rs1,              32'd0);
    chk("mid_resp0", {31'd0, bus.resp0_valid}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    contend(7'd3, 32'd1, 32'd31, 32'h8000_0000, 7'd4, 32'hFFFF_FFFF, 32'd1, 32'd1, "post_rst");

    // Randomized sweep.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [6:0]  c;
        logic [31:0] a, b;
        c = 7'($urandom_range(1, 10));
        if ($urandom_range(0, 99) < 5) c = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd11;
        a = $urandom;
        b = ($urandom_range(0, 4) == 0) ? a : 32'($urandom);
        set_req(p[0], $urandom_range(0, 99) < 55, c, a, b);
      end
      bus.resp0_ready = $urandom_range(0, 99) < 70;
      bus.resp1_ready = $urandom_range(0, 99) < 70;
      step();
    end

    set_req(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 7'd0, 32'd0, 32'd0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    repeat (6) step();
    #2;
    chk("drain_idle", {31'd0, bus.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational ALU between two requesters (port 0: integer issue path, port 1: branch/compare unit) using valid/ready handshakes and round-robin arbitration. Accepts one operation at a time, latches its operands, drives the shared ALU, registers the result and returns it with a zero flag and an illegal-opcode flag on the matching response port. Sits between the issue logic and the ALU instance in the non-pipelined core.

## Interface
- DATA_WIDTH, 32, operand/result width
- CTRL_WIDTH, 7, ALU control code width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present on port n
- req0_ready / req1_ready  out  1  request on port n is accepted this cycle
- req0_rs1, req0_rs2 / req1_rs1, req1_rs2  in  DATA_WIDTH  operands
- req0_aluControl / req1_aluControl  in  CTRL_WIDTH  ALU code: 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND
- resp0_valid / resp1_valid  out  1  result held on port n
- resp0_ready / resp1_ready  in  1  consumer takes result on port n
- resp0_rd / resp1_rd  out  DATA_WIDTH  result
- resp0_zero / resp1_zero  out  1  result equals 0
- resp0_err / resp1_err  out  1  aluControl was outside 1..10
- alu_rs1, alu_rs2  out  DATA_WIDTH  to shared ALU
- alu_aluControl  out  CTRL_WIDTH  to shared ALU
- alu_rd  in  DATA_WIDTH  from shared ALU (combinational)
- busy  out  1  state is not IDLE

## Operation
- FSM: IDLE, EXEC, RESP.
- IDLE: choose a winner among the valid requesters. If exactly one is valid, that one wins. If both are valid, the port not equal to last_grant wins. Assert ready only for the winner. ready is combinational from the valid inputs and last_grant, and is 0 outside IDLE.
- On a handshake (valid && ready): latch rs1, rs2 and aluControl into the operand registers. Record the winner in owner and in last_grant. Go to EXEC.
- EXEC: alu_* outputs drive the latched operands. At the clock edge, capture alu_rd into the result register, zero = (alu_rd == 0), err = (aluControl == 0 || aluControl > 10). Go to RESP.
- RESP: assert resp<owner>_valid with the result. The other response port stays 0. When resp<owner>_ready is 1, go to IDLE. In the same cycle, deassert valid at the next edge.
- A response is held stable for as many cycles as ready stays low. No new request is accepted while a response is pending.
- Illegal code: the code is still forwarded to the ALU. The ALU yields 0, so the response is rd=0, zero=1, err=1. This is not an error stop.
- alu_* outputs hold the latched operand registers in every state. They are 0 after reset.

## Timing
- Reset (async assert, sync-to-clk deassert by the top level): state=IDLE, last_grant=1 (so port 0 wins the first tie), owner=0, operand/result registers=0. All resp*_valid=0, rd=0, zero=0, err=0, busy=0, alu_*=0.
- Handshake at edge T. EXEC during cycle T+1. resp_valid high from cycle T+2.
- With resp_ready held high, the response completes at edge T+2 and IDLE is in cycle T+3. The next handshake can occur at edge T+3. Minimum issue interval is 3 cycles.
- Simultaneous valids in IDLE: strict alternation. 0,1,0,1… under continuous contention.
- A requester that drops valid before ready is not served and leaves no state.
- A resp_ready on the non-owner port is ignored.
- Reset mid-EXEC or mid-RESP: the operation is discarded, no response is produced, and all outputs return to reset values immediately.

## Test plan
- Single ADD on port 0: rs1=5, rs2=7, code 1 -> req0_ready in the handshake cycle, resp0_valid 2 cycles later, rd=12, zero=0, err=0, resp1_valid=0 throughout.
- Contention: both ports valid from reset, port 0 SUB 3-3, port 1 SRA 0x80000000>>4 -> port 0 served first (rd=0, zero=1), then port 1 (rd=0xF8000000). A third pair of requests is served port 0 then port 1 again.
- Back-pressure: port 1 SLTU 1<2 with resp1_ready low for 5 cycles -> resp1_valid stays high and rd=1 stays stable. Both req*_ready stay 0 while waiting. IDLE follows the ready cycle.
- Illegal code 0 and code 11 on port 0 -> rd=0, zero=1, err=1. The FSM returns to IDLE normally.
- Reset mid-operation: assert rst_n=0 during EXEC -> all outputs are 0 asynchronously. After release, the next tie goes to port 0 and no stale response appears.
- Sweep: random operands over all codes 1..10 on both ports against a reference model -> every rd, zero and err matches, and every response appears on its owner's port.
